// File: rtl/cpu_multicycle.sv
// Multi-cycle MIPS-subset core with one shared req/ack memory port.
// Any fault (overflow, misaligned access, illegal instruction) parks the core in HALT until reset.
module cpu_multicycle #(
   parameter logic [31:0] RESET_PC         = 32'h0000_0000,
   parameter int          ADDR_WIDTH       = 32,
   parameter bit          TRAP_ON_OVERFLOW = 1'b1
) (
   input  logic                  clk,
   input  logic                  reset,
   output logic                  mem_req,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [31:0]           mem_wdata,
   input  logic [31:0]           mem_rdata,
   input  logic                  mem_ack,
   output logic                  halted,
   output logic [31:0]           pc_out,
   output logic                  retired
);

   typedef enum logic [2:0] {
      S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'h00, OP_J = 6'h02, OP_JAL = 6'h03, OP_BNE = 6'h05,
                          OP_ADDI  = 6'h08, OP_XORI = 6'h0E, OP_LW = 6'h23, OP_SW = 6'h2B;
   localparam logic [5:0] FN_JR = 6'h08, FN_ADD = 6'h20, FN_SUB = 6'h22, FN_SLT = 6'h2A;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d, ir_q, ir_d, a_q, a_d, b_q, b_d, pc4_q, pc4_d, alu_q, alu_d;
   logic        retired_q, retired_d;
   logic [31:0] rf_q [32];
   logic [31:0] rf_d [32];

   logic        rf_we;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata;

   logic [5:0]  op, funct;
   logic [4:0]  rs, rt, rd, shamt;
   logic [15:0] imm;
   logic [25:0] target;
   logic [31:0] sext_imm, zext_imm, br_off, jmp_tgt;
   logic [31:0] sum_ab, diff_ab, sum_ai;
   logic        ovf_add, ovf_sub, ovf_addi;
   logic        is_rtype, is_add, is_sub, is_slt, is_jr, is_addi, is_xori;
   logic        is_lw, is_sw, is_bne, is_j, is_jal, is_legal;

   assign op     = ir_q[31:26];
   assign rs     = ir_q[25:21];
   assign rt     = ir_q[20:16];
   assign rd     = ir_q[15:11];
   assign shamt  = ir_q[10:6];
   assign funct  = ir_q[5:0];
   assign imm    = ir_q[15:0];
   assign target = ir_q[25:0];

   assign sext_imm = {{16{imm[15]}}, imm};
   assign zext_imm = {16'h0000, imm};
   assign br_off   = {sext_imm[29:0], 2'b00};
   assign jmp_tgt  = {pc4_q[31:28], target, 2'b00};

   assign sum_ab  = a_q + b_q;
   assign diff_ab = a_q - b_q;
   assign sum_ai  = a_q + sext_imm;
   assign ovf_add  = (a_q[31] == b_q[31])      && (sum_ab[31]  != a_q[31]);
   assign ovf_sub  = (a_q[31] != b_q[31])      && (diff_ab[31] != a_q[31]);
   assign ovf_addi = (a_q[31] == sext_imm[31]) && (sum_ai[31]  != a_q[31]);

   // R-type encodings with a nonzero shift amount are treated as illegal.
   assign is_rtype = (op == OP_RTYPE) && (shamt == 5'd0);
   assign is_add   = is_rtype && (funct == FN_ADD);
   assign is_sub   = is_rtype && (funct == FN_SUB);
   assign is_slt   = is_rtype && (funct == FN_SLT);
   assign is_jr    = is_rtype && (funct == FN_JR);
   assign is_addi  = (op == OP_ADDI);
   assign is_xori  = (op == OP_XORI);
   assign is_lw    = (op == OP_LW);
   assign is_sw    = (op == OP_SW);
   assign is_bne   = (op == OP_BNE);
   assign is_j     = (op == OP_J);
   assign is_jal   = (op == OP_JAL);
   assign is_legal = is_add | is_sub | is_slt | is_jr | is_addi | is_xori |
                     is_lw | is_sw | is_bne | is_j | is_jal;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_FETCH;
         pc_q      <= RESET_PC;
         ir_q      <= '0;
         a_q       <= '0;
         b_q       <= '0;
         pc4_q     <= '0;
         alu_q     <= '0;
         retired_q <= 1'b0;
         for (int i = 0; i < 32; i++) rf_q[i] <= '0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         ir_q      <= ir_d;
         a_q       <= a_d;
         b_q       <= b_d;
         pc4_q     <= pc4_d;
         alu_q     <= alu_d;
         retired_q <= retired_d;
         rf_q      <= rf_d;
      end
   end

   always_comb begin
      rf_d = rf_q;
      if (rf_we && (rf_waddr != 5'd0)) rf_d[rf_waddr] = rf_wdata;
   end

   // pc only moves when an instruction retires, so a trap leaves it on the faulting instruction.
   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      ir_d      = ir_q;
      a_d       = a_q;
      b_d       = b_q;
      pc4_d     = pc4_q;
      alu_d     = alu_q;
      retired_d = 1'b0;
      rf_we     = 1'b0;
      rf_waddr  = 5'd0;
      rf_wdata  = '0;
      case (state_q)
         S_FETCH: begin
            if (pc_q[1:0] != 2'b00) begin
               state_d = S_HALT;
            end else if (mem_ack) begin
               ir_d    = mem_rdata;
               state_d = S_DECODE;
            end
         end
         S_DECODE: begin
            a_d     = (rs == 5'd0) ? 32'h0 : rf_q[rs];
            b_d     = (rt == 5'd0) ? 32'h0 : rf_q[rt];
            pc4_d   = pc_q + 32'd4;
            state_d = is_legal ? S_EXEC : S_HALT;
         end
         S_EXEC: begin
            if (is_add || is_sub || is_addi) begin
               if (TRAP_ON_OVERFLOW && ((is_add && ovf_add) || (is_sub && ovf_sub) ||
                                        (is_addi && ovf_addi))) begin
                  state_d = S_HALT;
               end else begin
                  alu_d   = is_add ? sum_ab : (is_sub ? diff_ab : sum_ai);
                  state_d = S_WB;
               end
            end else if (is_slt) begin
               alu_d   = {31'd0, $signed(a_q) < $signed(b_q)};
               state_d = S_WB;
            end else if (is_xori) begin
               alu_d   = a_q ^ zext_imm;
               state_d = S_WB;
            end else if (is_lw || is_sw) begin
               alu_d   = sum_ai;
               state_d = (sum_ai[1:0] != 2'b00) ? S_HALT : S_MEM;
            end else if (is_bne || is_j || is_jal || is_jr) begin
               if (is_bne)     pc_d = (a_q != b_q) ? pc4_q + br_off : pc4_q;
               else if (is_jr) pc_d = a_q;
               else            pc_d = jmp_tgt;
               if (is_jal) begin
                  rf_we    = 1'b1;
                  rf_waddr = 5'd31;
                  rf_wdata = pc4_q;
               end
               retired_d = 1'b1;
               state_d   = S_FETCH;
            end else begin
               state_d = S_HALT;
            end
         end
         S_MEM: begin
            if (mem_ack) begin
               if (is_sw) begin
                  pc_d      = pc4_q;
                  retired_d = 1'b1;
                  state_d   = S_FETCH;
               end else begin
                  alu_d   = mem_rdata;
                  state_d = S_WB;
               end
            end
         end
         S_WB: begin
            rf_we     = 1'b1;
            rf_waddr  = (op == OP_RTYPE) ? rd : rt;
            rf_wdata  = alu_q;
            pc_d      = pc4_q;
            retired_d = 1'b1;
            state_d   = S_FETCH;
         end
         default: state_d = S_HALT;
      endcase
   end

   always_comb begin
      logic [31:0] addr_full;
      mem_req   = !reset && (((state_q == S_FETCH) && (pc_q[1:0] == 2'b00)) || (state_q == S_MEM));
      mem_we    = !reset && (state_q == S_MEM) && is_sw;
      addr_full = (state_q == S_MEM) ? alu_q : pc_q;
      mem_addr  = addr_full[ADDR_WIDTH-1:0];
      mem_wdata = b_q;
      halted    = (state_q == S_HALT);
      pc_out    = pc_q;
      retired   = retired_q;
   end

endmodule

// File: tb/tb_cpu_multicycle.sv
// Directed bench for cpu_multicycle: a vector table for the main program plus hand-written
// sequences for wait states, traps and reset during a pending fetch.
module tb_cpu_multicycle;

   localparam logic [5:0] OP_J = 6'h02, OP_JAL = 6'h03, OP_BNE = 6'h05, OP_ADDI = 6'h08,
                          OP_XORI = 6'h0E, OP_LW = 6'h23, OP_SW = 6'h2B;
   localparam logic [5:0] FN_JR = 6'h08, FN_ADD = 6'h20, FN_SUB = 6'h22, FN_SLT = 6'h2A;

   logic        clk, reset, reset_1;
   logic        mem_req, mem_we, mem_ack, halted, retired;
   logic [31:0] mem_addr, mem_wdata, mem_rdata, pc_out;
   logic        mem_req_1, mem_we_1, mem_ack_1, halted_1, retired_1;
   logic [31:0] mem_addr_1, mem_wdata_1, mem_rdata_1, pc_out_1;

   logic [31:0] mem0 [0:127];
   logic [31:0] mem1 [0:127];
   int          ack_delay;
   int          wait_cnt;
   int          n_tests, n_fail;

   typedef struct {
      logic [31:0] exp_pc;
      int          exp_cycles;
      int          chk_reg;
      logic [31:0] exp_val;
   } vec_t;
   vec_t vecs [14];

   cpu_multicycle dut (
      .clk(clk), .reset(reset), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack), .halted(halted),
      .pc_out(pc_out), .retired(retired)
   );

   cpu_multicycle #(.TRAP_ON_OVERFLOW(1'b0)) dut_wrap (
      .clk(clk), .reset(reset_1), .mem_req(mem_req_1), .mem_we(mem_we_1), .mem_addr(mem_addr_1),
      .mem_wdata(mem_wdata_1), .mem_rdata(mem_rdata_1), .mem_ack(mem_ack_1), .halted(halted_1),
      .pc_out(pc_out_1), .retired(retired_1)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Memory model: ack arrives after ack_delay wait cycles of a pending request.
   assign mem_ack     = mem_req && (wait_cnt >= ack_delay);
   assign mem_rdata   = mem0[mem_addr[8:2]];
   assign mem_ack_1   = mem_req_1;
   assign mem_rdata_1 = mem1[mem_addr_1[8:2]];

   always @(posedge clk) begin
      if (reset || !mem_req || mem_ack) wait_cnt <= 0;
      else                              wait_cnt <= wait_cnt + 1;
      if (mem_req && mem_we && mem_ack) mem0[mem_addr[8:2]] <= mem_wdata;
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   function automatic logic [31:0] enc_r(logic [4:0] rs, logic [4:0] rt, logic [4:0] rd,
                                         logic [5:0] fn);
      return {6'd0, rs, rt, rd, 5'd0, fn};
   endfunction

   function automatic logic [31:0] enc_i(logic [5:0] op, logic [4:0] rs, logic [4:0] rt,
                                         logic [15:0] imm);
      return {op, rs, rt, imm};
   endfunction

   function automatic logic [31:0] enc_j(logic [5:0] op, logic [25:0] tgt);
      return {op, tgt};
   endfunction

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic clear_mems();
      for (int i = 0; i < 128; i++) begin
         mem0[i] <= 32'h0;
         mem1[i] <= 32'h0;
      end
   endtask

   // Holds reset across an edge, applies the memory image set up by the caller, then releases.
   task automatic apply_stimulus(input int delay);
      reset     = 1'b1;
      ack_delay = delay;
      @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   // Steps clocks until retired, checking that a pending request holds its address.
   task automatic wait_retire(input string name, output int cycles);
      bit          pending;
      logic [31:0] addr;
      bit          seen;
      cycles = 0;
      seen   = 1'b0;
      for (int i = 0; i < 80; i++) begin
         pending = mem_req && !mem_ack;
         addr    = mem_addr;
         @(posedge clk);
         #1;
         cycles++;
         if (pending) begin
            check_output({name, " req_held"}, {31'd0, mem_req}, 32'd1);
            check_output({name, " addr_held"}, mem_addr, addr);
         end
         if (retired) begin
            seen = 1'b1;
            break;
         end
      end
      if (!seen) check_output({name, " retire_timeout"}, 32'd0, 32'd1);
   endtask

   task automatic wait_halt(input string name);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 80; i++) begin
         @(posedge clk);
         #1;
         if (halted) begin
            seen = 1'b1;
            break;
         end
      end
      if (!seen) check_output({name, " halt_timeout"}, 32'd0, 32'd1);
   endtask

   initial begin
      int cycles;
      n_tests   = 0;
      n_fail    = 0;
      ack_delay = 0;
      reset     = 1'b1;
      reset_1   = 1'b1;

      vecs[0]  = '{32'h04, 4, 1,  32'd5};
      vecs[1]  = '{32'h08, 4, 2,  32'hFFFF_FFFD};
      vecs[2]  = '{32'h0C, 4, 3,  32'd2};
      vecs[3]  = '{32'h10, 4, 3,  32'd2};
      vecs[4]  = '{32'h14, 5, 4,  32'd2};
      vecs[5]  = '{32'h18, 4, 5,  32'd8};
      vecs[6]  = '{32'h1C, 4, 6,  32'd1};
      vecs[7]  = '{32'h20, 4, 7,  32'hFFFF_0002};
      vecs[8]  = '{32'h30, 3, 31, 32'h24};
      vecs[9]  = '{32'h34, 4, 0,  32'd0};
      vecs[10] = '{32'h38, 3, 1,  32'd5};
      vecs[11] = '{32'h24, 3, 31, 32'h24};
      vecs[12] = '{32'h24, 3, 2,  32'hFFFF_FFFD};
      vecs[13] = '{32'h24, 3, 3,  32'd2};

      repeat (2) @(posedge clk);
      #1;
      check_output("rst mem_req", {31'd0, mem_req}, 32'd0);
      check_output("rst mem_we", {31'd0, mem_we}, 32'd0);
      check_output("rst halted", {31'd0, halted}, 32'd0);
      check_output("rst retired", {31'd0, retired}, 32'd0);
      check_output("rst pc", pc_out, 32'h0);

      // Main program, zero-wait memory.
      clear_mems();
      mem0[0]  <= enc_i(OP_ADDI, 5'd0, 5'd1, 16'd5);
      mem0[1]  <= enc_i(OP_ADDI, 5'd0, 5'd2, 16'hFFFD);
      mem0[2]  <= enc_r(5'd1, 5'd2, 5'd3, FN_ADD);
      mem0[3]  <= enc_i(OP_SW, 5'd0, 5'd3, 16'h0100);
      mem0[4]  <= enc_i(OP_LW, 5'd0, 5'd4, 16'h0100);
      mem0[5]  <= enc_r(5'd1, 5'd2, 5'd5, FN_SUB);
      mem0[6]  <= enc_r(5'd2, 5'd1, 5'd6, FN_SLT);
      mem0[7]  <= enc_i(OP_XORI, 5'd2, 5'd7, 16'hFFFF);
      mem0[8]  <= enc_j(OP_JAL, 26'd12);
      mem0[9]  <= enc_i(OP_BNE, 5'd1, 5'd2, 16'hFFFF);
      mem0[12] <= enc_i(OP_ADDI, 5'd0, 5'd0, 16'd7);
      mem0[13] <= enc_i(OP_BNE, 5'd1, 5'd1, 16'd5);
      mem0[14] <= enc_r(5'd31, 5'd0, 5'd0, FN_JR);
      apply_stimulus(0);
      for (int i = 0; i < 14; i++) begin
         wait_retire($sformatf("vec%0d", i), cycles);
         check_output($sformatf("vec%0d cycles", i), cycles, vecs[i].exp_cycles);
         check_output($sformatf("vec%0d pc", i), pc_out, vecs[i].exp_pc);
         check_output($sformatf("vec%0d R%0d", i, vecs[i].chk_reg), dut.rf_q[vecs[i].chk_reg],
                      vecs[i].exp_val);
         if (i == 3) check_output("sw mem[0x100]", mem0[64], 32'd2);
      end

      // Three wait cycles on every request.
      reset = 1'b1;
      @(posedge clk);
      #1;
      apply_stimulus(3);
      for (int i = 0; i < 3; i++) begin
         wait_retire($sformatf("slow%0d", i), cycles);
         check_output($sformatf("slow%0d cycles", i), cycles, 32'd7);
      end
      check_output("slow R3", dut.rf_q[3], 32'd2);
      check_output("slow pc", pc_out, 32'h0C);

      // Overflow: trapping core halts on the ADD, wrapping core writes 0x8000_0000.
      reset = 1'b1;
      @(posedge clk);
      #1;
      clear_mems();
      mem0[0]  <= enc_i(OP_ADDI, 5'd0, 5'd5, 16'h7FFF);
      mem0[1]  <= enc_i(OP_LW, 5'd0, 5'd1, 16'h0100);
      mem0[2]  <= enc_i(OP_ADDI, 5'd0, 5'd2, 16'd1);
      mem0[3]  <= enc_r(5'd1, 5'd2, 5'd3, FN_ADD);
      mem0[64] <= 32'h7FFF_FFFF;
      mem1[0]  <= enc_i(OP_ADDI, 5'd0, 5'd5, 16'h7FFF);
      mem1[1]  <= enc_i(OP_LW, 5'd0, 5'd1, 16'h0100);
      mem1[2]  <= enc_i(OP_ADDI, 5'd0, 5'd2, 16'd1);
      mem1[3]  <= enc_r(5'd1, 5'd2, 5'd3, FN_ADD);
      mem1[64] <= 32'h7FFF_FFFF;
      reset_1 = 1'b0;
      apply_stimulus(0);
      wait_halt("ovf");
      check_output("ovf R5", dut.rf_q[5], 32'h0000_7FFF);
      check_output("ovf R3 unchanged", dut.rf_q[3], 32'h0);
      check_output("ovf pc", pc_out, 32'h0C);
      check_output("ovf mem_req", {31'd0, mem_req}, 32'd0);
      repeat (5) @(posedge clk);
      #1;
      check_output("ovf halted sticky", {31'd0, halted}, 32'd1);
      check_output("ovf pc held", pc_out, 32'h0C);
      for (int i = 0; i < 40 && !halted_1; i++) begin
         @(posedge clk);
         #1;
      end
      check_output("wrap R3", dut_wrap.rf_q[3], 32'h8000_0000);
      check_output("wrap halted on illegal", {31'd0, halted_1}, 32'd1);
      check_output("wrap pc", pc_out_1, 32'h10);
      reset_1 = 1'b1;

      // Misaligned load: ea = 2 + 4 = 6.
      reset = 1'b1;
      @(posedge clk);
      #1;
      clear_mems();
      mem0[0] <= enc_i(OP_ADDI, 5'd0, 5'd1, 16'd2);
      mem0[1] <= enc_i(OP_LW, 5'd1, 5'd4, 16'd4);
      apply_stimulus(0);
      wait_halt("lw6");
      check_output("lw6 pc", pc_out, 32'h04);
      check_output("lw6 R4", dut.rf_q[4], 32'h0);
      check_output("lw6 mem_req", {31'd0, mem_req}, 32'd0);

      // Illegal opcode at the reset vector.
      reset = 1'b1;
      @(posedge clk);
      #1;
      clear_mems();
      mem0[0] <= 32'hFC00_0000;
      apply_stimulus(0);
      wait_halt("illegal");
      check_output("illegal pc", pc_out, 32'h0);

      // JR to a misaligned target halts at the next fetch without a request.
      reset = 1'b1;
      @(posedge clk);
      #1;
      clear_mems();
      mem0[0] <= enc_i(OP_ADDI, 5'd0, 5'd1, 16'h0042);
      mem0[1] <= enc_r(5'd1, 5'd0, 5'd0, FN_JR);
      apply_stimulus(0);
      wait_halt("jrmis");
      check_output("jrmis pc", pc_out, 32'h42);
      check_output("jrmis mem_req", {31'd0, mem_req}, 32'd0);

      // Reset while a fetch is waiting for ack.
      reset = 1'b1;
      @(posedge clk);
      #1;
      clear_mems();
      mem0[0] <= enc_i(OP_ADDI, 5'd0, 5'd1, 16'd5);
      mem0[1] <= enc_i(OP_ADDI, 5'd0, 5'd2, 16'd7);
      apply_stimulus(0);
      wait_retire("pre", cycles);
      ack_delay = 50;
      repeat (3) @(posedge clk);
      #1;
      check_output("wait mem_req", {31'd0, mem_req}, 32'd1);
      check_output("wait addr", mem_addr, 32'h04);
      reset = 1'b1;
      @(posedge clk);
      #1;
      check_output("rstmid mem_req", {31'd0, mem_req}, 32'd0);
      check_output("rstmid pc", pc_out, 32'h0);
      check_output("rstmid R1", dut.rf_q[1], 32'h0);
      ack_delay = 0;
      reset     = 1'b0;
      #1;
      check_output("restart addr", mem_addr, 32'h0);
      check_output("restart req", {31'd0, mem_req}, 32'd1);
      wait_retire("restart", cycles);
      check_output("restart cycles", cycles, 32'd4);
      check_output("restart R1", dut.rf_q[1], 32'd5);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
